demux_stream: RTL and testbench
===============================

DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 SHALL have parameter WD, default 8, width in bits of each data word.
REQ-002 SHALL have parameter bitsel, default 2, width of the channel select; the block has N = 2**bitsel output channels.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port in_data, input, WD, the source data word.
REQ-006 SHALL have port in_sel, input, bitsel, the destination channel index.
REQ-007 SHALL have port in_valid, input, 1, asserted when the source offers a word.
REQ-008 SHALL have port in_ready, output, 1, asserted when the block accepts a word this cycle.
REQ-009 SHALL have port out_data, output, unpacked array [N] of WD, the per-channel registered data.
REQ-010 SHALL have port out_valid, output, N, the per-channel holding-register-full flags.
REQ-011 SHALL have port out_ready, input, N, the per-channel sink-ready flags.
REQ-012 SHALL have port xfer_cnt, output, 16, the count of accepted input words.

Function
REQ-013 SHALL give each channel k a one-entry holding register (data_k, valid_k) driving out_data[k] and out_valid[k].
REQ-014 SHALL select target channel t = in_sel when DEMUX_RR_EN is undefined.
REQ-015 SHALL drive in_ready = ~valid_t | out_ready[t], combinationally, with no dependence on in_valid.
REQ-016 SHALL accept a word when in_valid & in_ready, loading in_data into data_t and setting valid_t on the next edge; latency is exactly 1 cycle.
REQ-017 SHALL drain channel k when out_valid[k] & out_ready[k], clearing valid_k on the next edge unless channel k is also loaded in the same cycle.
REQ-018 SHALL, on a simultaneous load and drain of the same channel, keep valid_t = 1 and replace data_t with the new word; no bubble, no loss.
REQ-019 SHALL let channels drain independently and concurrently; a stalled channel does not block acceptance for other channels.
REQ-020 SHALL hold data_k stable while out_valid[k] = 1 and out_ready[k] = 0.
REQ-021 SHALL leave data_k unchanged when a channel is drained without a load; only valid_k clears.
REQ-022 SHALL increment xfer_cnt by 1 per accepted word, wrapping modulo 2**16 (0xFFFF -> 0x0000).
REQ-023 SHALL ignore in_data and in_sel when in_valid = 0, with no state change.

Reset
REQ-024 SHALL, on rst_n low at any time, immediately clear every out_valid bit, zero every out_data entry and xfer_cnt, and zero the round-robin pointer when present.
REQ-025 SHALL discard held words on reset mid-operation, with no partial transfer after release.
REQ-026 SHALL accept a word on the first rising edge after rst_n deasserts if in_valid = 1 (in_ready = 1 because all channels are empty).

Configuration
REQ-027 SHALL, when macro DEMUX_RR_EN is defined, ignore in_sel and use a bitsel-wide round-robin pointer as t; the pointer advances by 1 mod N after each accepted word and holds otherwise.
REQ-028 SHALL, when DEMUX_RR_EN is undefined, contain no pointer register and route solely by in_sel.

Verification
REQ-029 SHALL verify basic routing: WD=8, bitsel=2, all out_ready=1, send 0xA5 sel=2 -> next cycle out_valid=4'b0100, out_data[2]=0xA5, xfer_cnt=1.
REQ-030 SHALL verify backpressure: out_ready[1]=0, send 0x11 then 0x22 to sel=1 -> second word sees in_ready=0 and out_data[1] holds 0x11; raise out_ready[1] -> 0x22 accepted in the same cycle, out_valid[1] stays 1.
REQ-031 SHALL verify independent channels: channel 0 full and stalled, send 0x33 to sel=3 -> accepted, out_valid=4'b1001.
REQ-032 SHALL verify counter wrap: preload with 65535 accepts, one more accept -> xfer_cnt=0x0000.
REQ-033 SHALL verify reset mid-operation: channels 0 and 2 full, pulse rst_n low between edges -> out_valid=0, out_data all 0x00, xfer_cnt=0 immediately, without waiting for a clock edge.
REQ-034 SHALL verify round-robin with DEMUX_RR_EN defined: send 0x01..0x05 with in_sel=0 -> words land on channels 0,1,2,3,0.

Source files
------------

// File: rtl/demux_stream.sv
// One-to-N stream demultiplexer with a one-entry holding register per output channel.
// Define DEMUX_RR_EN to ignore in_sel and route words round-robin across channels.
module demux_stream #(
    parameter int WD     = 8,
    parameter int bitsel = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WD-1:0]            in_data,
    input  logic [bitsel-1:0]        in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WD-1:0]            out_data [2**bitsel],
    output logic [(2**bitsel)-1:0]   out_valid,
    input  logic [(2**bitsel)-1:0]   out_ready,
    output logic [15:0]              xfer_cnt
);

    localparam int N = 2 ** bitsel;

    logic [bitsel-1:0] tgt;
    logic              accept;

`ifdef DEMUX_RR_EN
    logic [bitsel-1:0] rr_ptr;

    assign tgt = rr_ptr;

    // Pointer is exactly bitsel wide, so the natural wrap gives mod-N advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= rr_ptr + 1'b1;
        end
    end
`else
    assign tgt = in_sel;
`endif

    // A full channel can still take a word when its sink empties it on the same edge.
    assign in_ready = ~out_valid[tgt] | out_ready[tgt];
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            xfer_cnt  <= '0;
            // NOTE: the data registers are reset as well because outputs must read zero
            // during reset; a plain storage array would normally be left unreset.
            for (int k = 0; k < N; k++) begin
                out_data[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments here so every channel sees the same
            // pre-edge state regardless of loop order.
            for (int k = 0; k < N; k++) begin
                if (accept && (tgt == bitsel'(k))) begin
                    out_data[k]  <= in_data;
                    out_valid[k] <= 1'b1;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
            if (accept) begin
                xfer_cnt <= xfer_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_demux_stream.sv
// Randomized scoreboard bench for demux_stream: stimulus pushes expected words per channel,
// a monitor pops them on each output handshake.
module tb_demux_stream;

    localparam int WD = 8;
    localparam int BS = 2;
    localparam int N  = 4;

    logic          clk;
    logic          rst_n;
    logic [WD-1:0] in_data;
    logic [BS-1:0] in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [WD-1:0] out_data [N];
    logic [N-1:0]  out_valid;
    logic [N-1:0]  out_ready;
    logic [15:0]   xfer_cnt;

    demux_stream #(.WD(WD), .bitsel(BS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Reference model: per-channel queue of words still held, last word landed, accept count.
    logic [WD-1:0] exp_q [N][$];
    logic [WD-1:0] last_data [N];
    logic [15:0]   model_cnt = 16'd0;
    int            model_rr  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            exp_q[k].delete();
            last_data[k] = '0;
        end
        model_cnt = 16'd0;
        model_rr  = 0;
    endtask

    // Drive one cycle at the falling edge, then predict readiness and record any accepted word.
    task automatic cycle(input logic v, input logic [BS-1:0] s, input logic [WD-1:0] d,
                         input logic [N-1:0] r, output logic rdy);
        int  t;
        logic exp_rdy;
        @(negedge clk);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #2;
`ifdef DEMUX_RR_EN
        t = model_rr;
`else
        t = int'(s);
`endif
        exp_rdy = (exp_q[t].size() == 0) || r[t];
        rdy = in_ready;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (v && exp_rdy) begin
            exp_q[t].push_back(d);
            last_data[t] = d;
            model_cnt    = model_cnt + 16'd1;
            model_rr     = (model_rr + 1) % N;
        end
    endtask

    task automatic idle(input logic [N-1:0] r);
        logic rdy;
        cycle(1'b0, BS'($urandom_range(0, N - 1)), 8'($urandom), r, rdy);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_valid"}, 32'(out_valid), 32'(0));
        check({name, "_cnt"}, 32'(xfer_cnt), 32'(0));
        for (int k = 0; k < N; k++) begin
            check({name, "_data"}, 32'(out_data[k]), 32'(0));
        end
    endtask

    // Reset asserted and released strictly between clock edges.
    task automatic reset_mid();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("reset_async");
        model_clear();
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares held state with the model and pops one word per output handshake.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                check("out_valid", 32'(out_valid[k]), 32'(exp_q[k].size() != 0));
                check("out_data", 32'(out_data[k]), 32'(last_data[k]));
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        check("unexpected_word", 32'(out_data[k]), 32'hFFFF_FFFF);
                    end else begin
                        check("drained_word", 32'(out_data[k]), 32'(exp_q[k].pop_front()));
                    end
                end
            end
            check("xfer_cnt", 32'(xfer_cnt), 32'(model_cnt));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic rdy;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        rst_n     = 1'b1;
        model_clear();
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_state("reset_init");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

`ifndef DEMUX_RR_EN
        // Basic routing.
        cycle(1'b1, 2'd2, 8'hA5, 4'b1111, rdy);
        @(posedge clk); #1;
        check("route_valid", 32'(out_valid), 32'(4'b0100));
        check("route_data", 32'(out_data[2]), 32'(8'hA5));
        check("route_cnt", 32'(xfer_cnt), 32'(1));
        idle(4'b1111);

        // Backpressure on channel 1, then release with a same-cycle reload.
        cycle(1'b1, 2'd1, 8'h11, 4'b1101, rdy);
        cycle(1'b1, 2'd1, 8'h22, 4'b1101, rdy);
        check("bp_stall_ready", 32'(rdy), 32'(0));
        check("bp_hold_data", 32'(out_data[1]), 32'(8'h11));
        cycle(1'b1, 2'd1, 8'h22, 4'b1111, rdy);
        check("bp_release_ready", 32'(rdy), 32'(1));
        @(posedge clk); #1;
        check("bp_valid_kept", 32'(out_valid[1]), 32'(1));
        check("bp_new_data", 32'(out_data[1]), 32'(8'h22));
        idle(4'b1111);

        // Stalled channel 0 does not block channel 3.
        cycle(1'b1, 2'd0, 8'h44, 4'b1110, rdy);
        cycle(1'b1, 2'd3, 8'h33, 4'b1110, rdy);
        check("indep_ready", 32'(rdy), 32'(1));
        @(posedge clk); #1;
        check("indep_valid", 32'(out_valid), 32'(4'b1001));
        idle(4'b1111);
        idle(4'b1111);

        // Reset with channels 0 and 2 holding words.
        cycle(1'b1, 2'd0, 8'h5A, 4'b0000, rdy);
        cycle(1'b1, 2'd2, 8'hC3, 4'b0000, rdy);
        cycle(1'b0, 2'd0, 8'h00, 4'b0000, rdy);
        reset_mid();
        cycle(1'b1, 2'd2, 8'h77, 4'b0000, rdy);
        check("post_reset_ready", 32'(rdy), 32'(1));
        @(posedge clk); #1;
        check("post_reset_valid", 32'(out_valid), 32'(4'b0100));
        idle(4'b1111);
`else
        // Round-robin: in_sel held at 0, words walk 0,1,2,3,0.
        begin
            int exp_ch [5] = '{0, 1, 2, 3, 0};
            for (int i = 0; i < 5; i++) begin
                cycle(1'b1, 2'd0, 8'(i + 1), 4'b1111, rdy);
                @(posedge clk); #1;
                check("rr_valid", 32'(out_valid), 32'(1) << exp_ch[i]);
                check("rr_data", 32'(out_data[exp_ch[i]]), 32'(i + 1));
            end
            idle(4'b1111);
        end
`endif

        // Randomized traffic with independent per-channel backpressure.
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 9) < 7), BS'($urandom_range(0, N - 1)), 8'($urandom),
                  4'($urandom), rdy);
            if (i == 1000) begin
                reset_mid();
            end
        end
        idle(4'b1111);

        // Counter wrap: 65535 accepts from a clean reset, then one more.
        reset_mid();
        for (int i = 0; i < 65535; i++) begin
            cycle(1'b1, BS'($urandom_range(0, N - 1)), 8'($urandom), 4'b1111, rdy);
        end
        @(posedge clk); #1;
        check("wrap_full", 32'(xfer_cnt), 32'(16'hFFFF));
        cycle(1'b1, BS'($urandom_range(0, N - 1)), 8'($urandom), 4'b1111, rdy);
        @(posedge clk); #1;
        check("wrap_zero", 32'(xfer_cnt), 32'(16'h0000));
        idle(4'b1111);
        idle(4'b1111);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
